dht_frame_decoder: RTL

DHT_FRAME_DECODER -- requirements
Module: dht_frame_decoder

---
 rtl/dht_pkg.sv | 26 ++
 rtl/dht_frame_decoder_if.sv | 31 +++
 rtl/bin2bcd8.sv | 52 +++++
 rtl/dht_frame_decoder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared state encoding, frame layout and checksum helper for the DHT frame decoder
package dht_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } dht_state_e;

    localparam int FRAME_W      = 40;
    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CSUM_LSB     = 0;
    localparam int BCD_W        = 12;

    // Payload is frame[39:8]; the sum wraps modulo 256 like the sensor's own checksum.
    function automatic logic [7:0] payload_sum(input logic [31:0] p);
        logic [7:0] s;
        s = p[31:24] + p[23:16] + p[15:8] + p[7:0];
        return s;
    endfunction

endpackage

// File: rtl/dht_frame_decoder_if.sv
// rtl/dht_frame_decoder_if.sv - frame input and decoded reading bundle between capture logic and decoder
interface dht_frame_decoder_if;
    import dht_pkg::*;

    logic               frame_valid;
    logic [FRAME_W-1:0] frame;
    logic [7:0]         hum_int;
    logic [7:0]         hum_dec;
    logic [7:0]         temp_int;
    logic [7:0]         temp_dec;
    logic [BCD_W-1:0]   hum_bcd;
    logic [BCD_W-1:0]   temp_bcd;
    logic               out_valid;
    logic               crc_err;
    logic [7:0]         err_cnt;
    logic               busy;
    logic               stale;

    modport master (
        output frame_valid, frame,
        input  hum_int, hum_dec, temp_int, temp_dec, hum_bcd, temp_bcd,
        input  out_valid, crc_err, err_cnt, busy, stale
    );

    modport slave (
        input  frame_valid, frame,
        output hum_int, hum_dec, temp_int, temp_dec, hum_bcd, temp_bcd,
        output out_valid, crc_err, err_cnt, busy, stale
    );

endinterface

// File: rtl/bin2bcd8.sv
// rtl/bin2bcd8.sv - sequential 8-bit binary to 3-digit BCD double-dabble converter
module bin2bcd8
    import dht_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int SR_W = BCD_W + 8;

    logic [SR_W-1:0] sr;
    logic [2:0]      cnt;

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] x);
        logic [SR_W-1:0] y;
        y = x;
        for (int i = 0; i < 3; i++) begin
            if (y[8 + 4*i +: 4] >= 4'd5)
                y[8 + 4*i +: 4] = y[8 + 4*i +: 4] + 4'd3;
        end
        y = y << 1;
        return y;
    endfunction

    // The first iteration is folded into the load so that eight iterations finish
    // seven cycles after start and done lands on the last conversion cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr  <= dabble_step({{BCD_W{1'b0}}, bin});
                cnt <= 3'd7;
            end else if (cnt != 3'd0) begin
                sr  <= dabble_step(sr);
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1)
                    done <= 1'b1;
            end
        end
    end

    assign bcd = sr[SR_W-1:8];

endmodule

// File: rtl/dht_frame_decoder.sv
// rtl/dht_frame_decoder.sv - validates DHT sensor frames, converts integer bytes to BCD, tracks staleness
module dht_frame_decoder
    import dht_pkg::*;
#(
    parameter int CLK_PER_MS = 100000,
    parameter int STALE_MS   = 3000
) (
    input  logic                clk,
    input  logic                rst,
    dht_frame_decoder_if.slave  bus
);

    localparam longint STALE_LIMIT = longint'(CLK_PER_MS) * longint'(STALE_MS);
    localparam int     CW          = $clog2(STALE_LIMIT + 1);
    localparam logic [CW-1:0] STALE_MAX = CW'(STALE_LIMIT);

    dht_state_e         state;
    logic [FRAME_W-1:0] frame_reg;
    logic [CW-1:0]      stale_cnt;
    logic               good;
    logic               start;
    logic               hum_done;
    logic               temp_done;
    logic [BCD_W-1:0]   hum_res;
    logic [BCD_W-1:0]   temp_res;
    logic               conv_end;

    assign good     = (payload_sum(frame_reg[FRAME_W-1:8]) == frame_reg[CSUM_LSB +: 8])
                      && (frame_reg != '0);
    assign start    = (state == CHECK) && good;
    assign conv_end = (state == CONV) && hum_done && temp_done;

    bin2bcd8 u_hum_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (frame_reg[HUM_INT_LSB +: 8]),
        .done  (hum_done),
        .bcd   (hum_res)
    );

    bin2bcd8 u_temp_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (frame_reg[TEMP_INT_LSB +: 8]),
        .done  (temp_done),
        .bcd   (temp_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            frame_reg    <= '0;
            stale_cnt    <= '0;
            bus.hum_int  <= '0;
            bus.hum_dec  <= '0;
            bus.temp_int <= '0;
            bus.temp_dec <= '0;
            bus.hum_bcd  <= '0;
            bus.temp_bcd <= '0;
            bus.out_valid <= 1'b0;
            bus.crc_err  <= 1'b0;
            bus.err_cnt  <= '0;
            bus.busy     <= 1'b0;
            bus.stale    <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
            bus.crc_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        frame_reg <= bus.frame;
                        state     <= CHECK;
                        bus.busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (good) begin
                        state <= CONV;
                    end else begin
                        bus.crc_err <= 1'b1;
                        if (bus.err_cnt != 8'hFF)
                            bus.err_cnt <= bus.err_cnt + 8'd1;
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                CONV: begin
                    if (conv_end) begin
                        bus.hum_int   <= frame_reg[HUM_INT_LSB +: 8];
                        bus.hum_dec   <= frame_reg[HUM_DEC_LSB +: 8];
                        bus.temp_int  <= frame_reg[TEMP_INT_LSB +: 8];
                        bus.temp_dec  <= frame_reg[TEMP_DEC_LSB +: 8];
                        bus.hum_bcd   <= hum_res;
                        bus.temp_bcd  <= temp_res;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // Cleared on the same edge that raises out_valid, so stale drops with the pulse.
            if (conv_end) begin
                stale_cnt <= '0;
                bus.stale <= 1'b0;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
                if (stale_cnt == STALE_MAX - 1'b1)
                    bus.stale <= 1'b1;
            end
        end
    end

endmodule
